decode24_seq: RTL and testbench
===============================

DECODE24_SEQ -- requirements
Module: decode24_seq

Interface
REQ-001 The block SHALL have parameter HOLD_W, default 4, giving the width of the hold-count input.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port clr, input, 1 bit, the synchronous abort that returns the block to idle.
REQ-005 The block SHALL have port valid_in, input, 1 bit, meaning a request is offered.
REQ-006 The block SHALL have port ready_out, output, 1 bit, meaning a request is accepted this cycle if valid_in=1.
REQ-007 The block SHALL have port x, input, 2 bits, the binary code to decode.
REQ-008 The block SHALL have port en, input, 1 bit, the decode enable, sampled with x.
REQ-009 The block SHALL have port hold, input, HOLD_W bits, the extra cycles to hold y (present only with DECODE24_SEQ_HOLD_EN).
REQ-010 The block SHALL have port y, output, 4 bits, the registered one-hot decode.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a decode is being driven.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the end of a drive.

Function
REQ-013 The FSM SHALL have two states: IDLE and DRIVE.
REQ-014 In IDLE: ready_out=1, busy=0, y=4'b0000.
REQ-015 In DRIVE: ready_out=0, busy=1, and y holds the captured one-hot value.
REQ-016 Accept SHALL mean valid_in=1 and ready_out=1 and clr=0 at a clock edge; x, en and hold are captured at that edge.
REQ-017 Accept with en=1 SHALL enter DRIVE with y=1<<x from the next cycle (x=0->0001, 1->0010, 2->0100, 3->1000) and load the counter with hold.
REQ-018 Accept with en=0 SHALL be consumed and discarded: the state stays IDLE, y stays 0000, and done stays 0.
REQ-019 In DRIVE the counter SHALL decrement each cycle; in the DRIVE cycle where counter==0, the next state is IDLE.
REQ-020 y SHALL therefore be nonzero for exactly hold+1 cycles; hold=0 gives 1 cycle and hold=2^HOLD_W-1 gives 2^HOLD_W cycles, with no wrap.
REQ-021 done SHALL be 1 for exactly the first IDLE cycle after a DRIVE that ends by count expiry.
REQ-022 A new accept SHALL be allowed in that same cycle, so back-to-back requests have a minimum one-cycle y=0000 gap.
REQ-023 valid_in in DRIVE SHALL be ignored (not accepted, not queued), and x, en and hold changes in DRIVE SHALL have no effect.
REQ-024 clr=1 in any state SHALL force IDLE, y=0000 and counter=0 at the next edge; done is not pulsed.
REQ-025 When clr=1 and valid_in=1 in the same cycle, clr SHALL win and there is no accept.
REQ-026 y SHALL never have more than one bit set, and SHALL never be nonzero while busy=0.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force IDLE, y=0000, busy=0, done=0, counter=0 and ready_out=1.
REQ-028 Reset asserted mid-DRIVE SHALL abort the drive with no done pulse.
REQ-029 Release of rst_n SHALL take effect at a clk edge, and the first accept SHALL be possible on the first edge after release.

Configuration
REQ-030 Macro DECODE24_SEQ_HOLD_EN defined: the hold port and down-counter SHALL exist and behave per REQ-017 to REQ-020.
REQ-031 Macro DECODE24_SEQ_HOLD_EN undefined: the hold port and counter SHALL be absent, and every DRIVE SHALL last exactly 1 cycle (as hold=0).

Verification
REQ-032 The bench SHALL cover reset then accept x=2, en=1, hold=3 -> y=0100 for 4 cycles, busy=1 throughout, then y=0000 with done=1 for 1 cycle.
REQ-033 The bench SHALL cover accept x=1, en=0 -> y stays 0000, busy=0, done=0, ready_out stays 1.
REQ-034 The bench SHALL cover valid_in held high for x=0 then x=3 with hold=0 -> y=0001, 0000 (done=1, second accept), 1000, 0000.
REQ-035 The bench SHALL cover clr=1 in the 2nd DRIVE cycle of a hold=5 request with valid_in=1 -> next cycle y=0000, IDLE, no done, no accept.
REQ-036 The bench SHALL cover rst_n pulsed low mid-DRIVE -> y=0000 and busy=0 without a clock edge, and no done after release.
REQ-037 The bench SHALL cover the macro undefined with accept x=3 -> y=1000 for exactly 1 cycle, then done=1.

Source files
------------

// File: rtl/decode24_seq.sv
// decode24_seq: registered 2-to-4 one-hot decoder with a request handshake.
// An accepted request with en=1 drives y = 1<<x for one or more cycles.
// When the drive ends by count expiry, done pulses for one cycle.
// An accepted request with en=0 is consumed and produces no output.
//
// Optional feature macro: DECODE24_SEQ_HOLD_EN
//   defined   : adds the hold input and a down-counter, so y is held for hold+1 cycles.
//   undefined : no hold input and no counter; every drive lasts exactly one cycle.
//
// state  | meaning
// S_IDLE | ready for a request; y=0000, busy=0
// S_DRIVE| y holds the captured one-hot code; busy=1, requests ignored
module decode24_seq #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        x,
  input  logic              en,
`ifdef DECODE24_SEQ_HOLD_EN
  input  logic [HOLD_W-1:0] hold,
`endif
  output logic [3:0]        y,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_y;
  logic        r_busy;
  logic        r_done;
  logic        r_ready;
`ifdef DECODE24_SEQ_HOLD_EN
  logic [HOLD_W-1:0] r_cnt;
  logic              w_last;

  // The drive ends in the cycle where the remaining count has reached zero.
  assign w_last = (r_cnt == '0);
`else
  logic              w_last;

  // Without a counter, every drive is a single cycle.
  assign w_last = 1'b1;
`endif

  // Controller FSM with all outputs registered. clr and reset both return the block to idle without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_y     <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
`ifdef DECODE24_SEQ_HOLD_EN
      r_cnt   <= '0;
`endif
    end else if (clr) begin
      r_state <= S_IDLE;
      r_y     <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
`ifdef DECODE24_SEQ_HOLD_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ready_out is 1 throughout idle, so valid_in alone means accept.
          // A request with en=0 is silently consumed.
          if (valid_in && en) begin
            r_state <= S_DRIVE;
            r_y     <= 4'b0001 << x;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
`ifdef DECODE24_SEQ_HOLD_EN
            r_cnt   <= hold;
`endif
          end
        end
        S_DRIVE: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_y     <= 4'b0000;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
`ifdef DECODE24_SEQ_HOLD_EN
            r_cnt   <= r_cnt - 1'b1;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_y     <= 4'b0000;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign y         = r_y;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ready_out = r_ready;

endmodule

// File: tb/tb_decode24_seq.sv
// Testbench for decode24_seq: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a drive-length model.
module tb_decode24_seq;

  localparam int HOLD_W = 4;
`ifdef DECODE24_SEQ_HOLD_EN
  localparam int HOLD_EN = 1;
`else
  localparam int HOLD_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              clr = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [1:0]        x = 2'd0;
  logic              en = 1'b0;
  logic [HOLD_W-1:0] hold = '0;
  logic [3:0]        y;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;

  // Model state: the number of cycles the current drive still shows y,
  // the captured code, and whether done is due this cycle.
  int         m_rem = 0;
  logic [3:0] m_code = 4'b0000;
  logic       m_done = 1'b0;

  decode24_seq #(.HOLD_W(HOLD_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .x(x),
    .en(en),
`ifdef DECODE24_SEQ_HOLD_EN
    .hold(hold),
`endif
    .y(y),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic int drive_len(input logic [HOLD_W-1:0] h);
    return (HOLD_EN != 0) ? int'(h) + 1 : 1;
  endfunction

  // Model: asynchronous reset empties the drive.
  always @(negedge rst_n) begin
    m_rem  = 0;
    m_done = 1'b0;
  end

  // Model: per-edge update from the specification's rules.
  always @(posedge clk) begin
    if (rst_n) begin
      if (clr) begin
        m_rem  = 0;
        m_done = 1'b0;
      end else if (m_rem > 0) begin
        m_rem  = m_rem - 1;
        m_done = (m_rem == 0);
      end else begin
        m_done = 1'b0;
        if (valid_in && en) begin
          m_rem  = drive_len(hold);
          m_code = 4'(4'b0001 << x);
        end
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    logic [3:0] e_y;
    logic       e_busy;
    e_busy = (m_rem > 0);
    e_y    = e_busy ? m_code : 4'b0000;
    checks = checks + 1;
    if (y !== e_y || busy !== e_busy || done !== m_done || ready_out !== !e_busy) begin
      failures = failures + 1;
      $display("FAIL model t=%0t got y=%b busy=%b done=%b ready=%b want y=%b busy=%b done=%b ready=%b",
               $time, y, busy, done, ready_out, e_y, e_busy, m_done, !e_busy);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] ey, input logic eb,
                     input logic ed, input logic er);
    checks = checks + 1;
    if (y !== ey || busy !== eb || done !== ed || ready_out !== er) begin
      failures = failures + 1;
      $display("FAIL %s got y=%b busy=%b done=%b ready=%b want y=%b busy=%b done=%b ready=%b",
               name, y, busy, done, ready_out, ey, eb, ed, er);
    end
  endtask

  initial begin
    int len;
    #1 rst_n = 1'b0;
    tick();
    chk("reset_async", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_state", 4'b0000, 1'b0, 1'b0, 1'b1);

    // x=2, en=1, hold=3
    valid_in = 1'b1; x = 2'd2; en = 1'b1; hold = 4'd3;
    len = drive_len(4'd3);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk("x2_drive", 4'b0100, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("x2_done", 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    chk("x2_after", 4'b0000, 1'b0, 1'b0, 1'b1);

    // x=1, en=0: consumed with no effect
    valid_in = 1'b1; x = 2'd1; en = 1'b0;
    tick();
    valid_in = 1'b0;
    chk("en0_a", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk("en0_b", 4'b0000, 1'b0, 1'b0, 1'b1);

    // valid held high: x=0 then x=3 with hold=0
    valid_in = 1'b1; x = 2'd0; en = 1'b1; hold = 4'd0;
    tick();
    x = 2'd3;
    chk("b2b_first", 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_gap", 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    valid_in = 1'b0;
    chk("b2b_second", 4'b1000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_done", 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();

    // clr with valid_in=1 in the 2nd drive cycle (only cycle without hold)
    valid_in = 1'b1; x = 2'd1; en = 1'b1; hold = 4'd5;
    tick();
    for (int i = 1; i < ((HOLD_EN != 0) ? 2 : 1); i++) tick();
    chk("clr_pre", 4'b0010, 1'b1, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0; valid_in = 1'b0;
    chk("clr_abort", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk("clr_after", 4'b0000, 1'b0, 1'b0, 1'b1);

    // reset mid-drive, then accept on first edge after release
    valid_in = 1'b1; x = 2'd3; en = 1'b1; hold = 4'd4;
    tick();
    valid_in = 1'b0;
    chk("rst_pre", 4'b1000, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_mid", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    valid_in = 1'b1; x = 2'd0; en = 1'b1; hold = 4'd0;
    tick();
    valid_in = 1'b0;
    chk("rst_first_accept", 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_first_done", 4'b0000, 1'b0, 1'b1, 1'b1);

    // x=3, hold=0: single-cycle drive in either build
    valid_in = 1'b1; x = 2'd3; en = 1'b1; hold = 4'd0;
    tick();
    valid_in = 1'b0;
    chk("x3_one", 4'b1000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("x3_done", 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();

    // Maximum hold: 16 cycles with the counter, no wrap
    valid_in = 1'b1; x = 2'd1; en = 1'b1; hold = 4'd15;
    tick();
    valid_in = 1'b0;
    len = drive_len(4'd15);
    for (int i = 0; i < len; i++) tick();
    chk("max_done", 4'b0000, 1'b0, 1'b1, 1'b1);

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 600; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      x        = 2'($urandom_range(0, 3));
      en       = ($urandom_range(0, 4) != 0);
      hold     = HOLD_W'($urandom_range(0, 6));
      clr      = ($urandom_range(0, 19) == 0);
      tick();
    end
    clr = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
